// File: rtl/phase_accumulator.sv
// DDS phase accumulator: f_out (Hz) -> tuning word via a reciprocal constant,
// then modulo-2^ACC_WIDTH accumulation with the top PHASE_WIDTH bits as the phase index.
module phase_accumulator #(
  parameter int unsigned FREQ_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned PHASE_WIDTH = 4,
  parameter int unsigned F_CLK       = 50_000_000,
  parameter int unsigned SCALE_SHIFT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FREQ_WIDTH-1:0]  f_out,
  output logic [PHASE_WIDTH-1:0] phase_acc
);

  localparam int unsigned KW = ACC_WIDTH + SCALE_SHIFT;
  localparam int unsigned PW = FREQ_WIDTH + ACC_WIDTH + SCALE_SHIFT;

  // K = round_half_up(2^KW / F_CLK) = floor((2^(KW+1) + F_CLK) / (2*F_CLK))
  localparam logic [KW+1:0] K_NUM  = ((KW+2)'(1) << (KW + 1)) + (KW+2)'(F_CLK);
  localparam logic [KW+1:0] K_DEN  = (KW+2)'(F_CLK) << 1;
  localparam logic [KW+1:0] K_FULL = K_NUM / K_DEN;
  localparam logic [KW-1:0] K      = K_FULL[KW-1:0];

  logic [FREQ_WIDTH-1:0] f_q;
  logic [ACC_WIDTH-1:0]  ftw;
  logic [ACC_WIDTH-1:0]  acc;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         shifted;
  logic [ACC_WIDTH-1:0]  ftw_next;

  always_comb begin
    prod    = PW'(f_q) * PW'(K);
    shifted = prod >> SCALE_SHIFT;
    if (|shifted[PW-1:ACC_WIDTH]) begin
      ftw_next = '1;
    end else begin
      ftw_next = shifted[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q <= '0;
      ftw <= '0;
      acc <= '0;
    end else begin
      f_q <= f_out;
      ftw <= ftw_next;
      acc <= acc + ftw;
    end
  end

  assign phase_acc = acc[ACC_WIDTH-1 -: PHASE_WIDTH];

endmodule

// File: tb/tb_phase_accumulator.sv
// Scoreboard bench for phase_accumulator: stimulus pushes expected accumulator
// values built from hand-computed tuning words; a monitor pops and compares.
module tb_phase_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] f_out = 32'd0;
  logic [3:0]  phase_acc;

  phase_accumulator #(
    .FREQ_WIDTH (32),
    .ACC_WIDTH  (32),
    .PHASE_WIDTH(4),
    .F_CLK      (50_000_000),
    .SCALE_SHIFT(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .f_out    (f_out),
    .phase_acc(phase_acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_fq  = '0;
  logic [31:0] m_ftw = '0;
  logic [31:0] m_acc = '0;

  // Hand-computed tuning words with K = 5629500, shift 16.
  function automatic logic [31:0] ftw_of(input logic [31:0] f);
    case (f)
      32'd0:        return 32'd0;
      32'd1:        return 32'd85;
      32'd500000:   return 32'd42949676;
      32'd3125000:  return 32'd268435478;
      32'd49999995: return 32'd4294967221;
      32'd49999996: return 32'hFFFF_FFFF;
      32'd50000000: return 32'hFFFF_FFFF;
      32'd60000000: return 32'hFFFF_FFFF;
      default:      return 32'd0;
    endcase
  endfunction

  task automatic push(input string tag);
    exp_t e;
    e.acc = m_acc;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic [31:0] f, input string tag);
    f_out = f;
    @(posedge clk);
    if (reset) begin
      m_fq  = '0;
      m_ftw = '0;
      m_acc = '0;
    end else begin
      m_acc = m_acc + m_ftw;
      m_ftw = ftw_of(m_fq);
      m_fq  = f;
    end
    push(tag);
    #1;
  endtask

  task automatic async_reset_now(input string tag);
    @(negedge clk);
    reset = 1'b1;
    m_fq  = '0;
    m_ftw = '0;
    m_acc = '0;
    push(tag);
    #2;
  endtask

  // Monitor: compares each expected entry one time unit after it is queued.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (dut.acc !== e.acc) begin
        errors++;
        $display("FAIL %s acc: got %0d expected %0d", e.tag, dut.acc, e.acc);
      end
      checks++;
      if (phase_acc !== e.acc[31:28]) begin
        errors++;
        $display("FAIL %s phase_acc: got %0d expected %0d", e.tag, phase_acc, e.acc[31:28]);
      end
    end
  end

  logic [31:0] table_f [8] = '{32'd0, 32'd1, 32'd500000, 32'd3125000,
                               32'd49999995, 32'd49999996, 32'd50000000, 32'd60000000};

  initial begin
    logic [31:0] f;
    int unsigned hold;

    f_out = 32'd500000;
    #1;
    reset = 1'b1;
    push("por");
    #2;
    tick(32'd500000, "por_hold");
    tick(32'd500000, "por_hold");
    reset = 1'b0;

    for (int i = 0; i < 12; i++) tick(32'd500000, "f500k");

    for (int i = 0; i < 40; i++) tick(32'd3125000, "f3125k");

    for (int i = 0; i < 8; i++) tick(32'd0, "freeze");
    for (int i = 0; i < 20; i++) tick(32'd3125000, "resume");

    for (int i = 0; i < 5; i++) tick(32'd1, "f1hz");

    async_reset_now("async_rst");
    for (int i = 0; i < 3; i++) tick(32'd60000000, "rst_hold");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick(32'd60000000, "saturate");

    for (int i = 0; i < 6; i++) tick(32'd3125000, "mid_count");
    async_reset_now("async_rst2");
    for (int i = 0; i < 4; i++) tick(32'd3125000, "rst_hold2");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) tick(32'd49999995, "below_sat");
    for (int i = 0; i < 10; i++) tick(32'd49999996, "at_sat");
    for (int i = 0; i < 10; i++) tick(32'd50000000, "fclk");

    for (int i = 0; i < 400; i++) begin
      f = table_f[$urandom_range(0, 7)];
      hold = $urandom_range(1, 8);
      for (int unsigned j = 0; j < hold; j++) tick(f, "mixed");
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
